// File: rtl/tone_sample_source.sv
// Gated square-wave tone source with a linear attack/release envelope.
// Feeds Audio_Controller; the controller's FIFO paces the sample rate.
module tone_sample_source #(
    parameter int PERIOD_W = 20,
    parameter int AMP_MAX  = 10000000,
    parameter int AMP_STEP = 100000,
    parameter int ENV_DIV  = 2500
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [PERIOD_W-1:0] note_period,
    input  logic                note_on,
    input  logic                audio_out_allowed,
    output logic [31:0]         left_channel_audio_out,
    output logic [31:0]         right_channel_audio_out,
    output logic                write_audio_out,
    output logic                busy
);

    localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ENV_DIV - 1);
    localparam logic [31:0]      AMP_MAX_V = 32'(AMP_MAX);
    localparam logic [31:0]      STEP_V    = 32'(AMP_STEP);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ATTACK  = 2'd1;
    localparam logic [1:0] SUSTAIN = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [PERIOD_W-1:0] phase_cnt;
    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] reload_cnt;
    logic                phase;
    logic                load_period;

    logic [DIV_W-1:0] env_div_cnt;
    logic             tick;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [31:0] amp;
    logic [31:0] amp_next;
    logic [32:0] amp_sum;
    logic [31:0] amp_up;
    logic [31:0] amp_dn;

    logic [31:0] sample;

    // Loading the period only at a phase boundary keeps every half-cycle whole.
    assign load_period = (phase_cnt == '0) || (state == IDLE);
    assign reload_cnt  = (note_period == '0) ? '0 : note_period - PERIOD_W'(1);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            period_q  <= '0;
            phase_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (load_period) begin
                period_q <= note_period;
            end
            if (period_q == '0) begin
                phase_cnt <= '0;
            end else if (phase_cnt == '0) begin
                phase     <= ~phase;
                phase_cnt <= reload_cnt;
            end else begin
                phase_cnt <= phase_cnt - PERIOD_W'(1);
            end
        end
    end

    assign tick = (env_div_cnt == DIV_LAST);

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            env_div_cnt <= '0;
        end else if (tick) begin
            env_div_cnt <= '0;
        end else begin
            env_div_cnt <= env_div_cnt + DIV_W'(1);
        end
    end

    assign amp_sum = {1'b0, amp} + {1'b0, STEP_V};
    assign amp_up  = (amp_sum >= {1'b0, AMP_MAX_V}) ? AMP_MAX_V : amp_sum[31:0];
    assign amp_dn  = (amp <= STEP_V) ? 32'd0 : amp - STEP_V;

    // A gate change on a tick moves state but leaves amp untouched that tick.
    always_comb begin
        state_next = state;
        amp_next   = amp;
        if (tick) begin
            case (state)
                IDLE: begin
                    amp_next = 32'd0;
                    if (note_on && (note_period != '0)) begin
                        state_next = ATTACK;
                    end
                end
                ATTACK: begin
                    if (!note_on) begin
                        state_next = RELEASE;
                    end else begin
                        amp_next = amp_up;
                        if (amp_up == AMP_MAX_V) begin
                            state_next = SUSTAIN;
                        end
                    end
                end
                SUSTAIN: begin
                    amp_next = AMP_MAX_V;
                    if (!note_on) begin
                        state_next = RELEASE;
                    end
                end
                RELEASE: begin
                    if (note_on) begin
                        state_next = ATTACK;
                    end else begin
                        amp_next = amp_dn;
                        if (amp_dn == 32'd0) begin
                            state_next = IDLE;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    amp_next   = 32'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            amp   <= 32'd0;
        end else begin
            state <= state_next;
            amp   <= amp_next;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sample <= 32'd0;
        end else if ((period_q == '0) || (state == IDLE)) begin
            sample <= 32'd0;
        end else if (phase) begin
            sample <= amp;
        end else begin
            sample <= 32'd0 - amp;
        end
    end

    // Handshake: the sample register is always valid; a write happens on every
    // cycle the FIFO reports space, with no buffering or replay.
    assign write_audio_out         = audio_out_allowed & resetn;
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;
    assign busy                    = (state != IDLE);

endmodule
